axi_lite_wr_regfile: RTL

- AXI-lite write-channel slave that sits directly downstream of an AXI-lite write master, on the slave modport side.
- Accepts AW and W beats independently, in either order or in the same cycle.
- Commits byte-strobed writes into a flat register bank and returns a B response.
- The register bank drives a flat bus to downstream control logic, plus a one-cycle write-notify pulse.

---
 rtl/axi_lite_wr_regfile.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_wr_regfile.sv
// AXI-lite write-channel slave backed by a flat, byte-strobed register bank.
// Accepts one AW beat and one W beat in any order, commits the write in a
// single COMMIT cycle, then holds the B response until it is taken.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   awaddr/awvalid/awready   AW channel (byte address)
//   wdata/wstrb/wvalid/wready W channel
//   bresp/bvalid/bready      B channel (OKAY or SLVERR)
//   reg_q               register bank, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse, wr_idx    one-cycle notify of an in-range register write
module axi_lite_wr_regfile #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8,
    localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [STRB_W-1:0]              wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic                           wr_pulse,
    output logic [IDX_W-1:0]               wr_idx
);

    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned BANK_W = NUM_REGS * DATA_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMMIT  = 2'd1,
        RESP    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
    logic [BANK_W-1:0]       bank_q, bank_d;

    logic                    aw_hs;
    logic                    w_hs;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;

    // Handshakes and address decode; the full shifted address is compared so
    // set upper bits fall out of range instead of aliasing onto a register.
    always_comb begin
        aw_hs     = awvalid & awready_q;
        w_hs      = wvalid & wready_q;
        word_addr = awaddr_q >> LSB;
        in_range  = (word_addr < ADDR_WIDTH'(NUM_REGS));
        idx       = word_addr[IDX_W-1:0];
    end

    // Next-state, buffer and output logic.
    always_comb begin
        state_d    = state_q;
        aw_full_d  = aw_full_q;
        awaddr_d   = awaddr_q;
        w_full_d   = w_full_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        bank_d     = bank_q;

        case (state_q)
            COLLECT: begin
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    awaddr_d  = awaddr;
                end
                if (w_hs) begin
                    w_full_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (aw_full_d && w_full_d) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                bvalid_d  = 1'b1;
                state_d   = RESP;
                if (in_range) begin
                    bresp_d    = RESP_OKAY;
                    wr_pulse_d = 1'b1;
                    wr_idx_d   = idx;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if ((IDX_W'(i) == idx) && wstrb_q[b]) begin
                                bank_d[i*DATA_WIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
                            end
                        end
                    end
                end else begin
                    bresp_d = RESP_SLVERR;
                end
            end
            RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        // Ready is based on the current state, so it reopens one cycle after
        // returning to COLLECT and never during COMMIT or RESP.
        awready_d = (state_q == COLLECT) && !aw_full_d;
        wready_d  = (state_q == COLLECT) && !w_full_d;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            aw_full_q  <= 1'b0;
            awaddr_q   <= '0;
            w_full_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            bank_q     <= '0;
        end else begin
            state_q    <= state_d;
            aw_full_q  <= aw_full_d;
            awaddr_q   <= awaddr_d;
            w_full_q   <= w_full_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            bank_q     <= bank_d;
        end
    end

    assign awready  = awready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_idx   = wr_idx_q;
    assign reg_q    = bank_q;

endmodule
